// File: rtl/intdiv_pkg.sv
// Shared bexkat1 definitions used by the integer divide unit.
//   intfunc_t      : integer calculator operation select
//   intdiv_state_t : divide unit control states
package bexkat1Def;

  typedef enum logic [3:0] {
    INT_ADD  = 4'h0,
    INT_SUB  = 4'h1,
    INT_MUL  = 4'h2,
    INT_AND  = 4'h3,
    INT_OR   = 4'h4,
    INT_XOR  = 4'h5,
    INT_COM  = 4'h6,
    INT_NEG  = 4'h7,
    INT_LSL  = 4'h8,
    INT_LSR  = 4'h9,
    INT_ASR  = 4'hA,
    INT_CMP  = 4'hB,
    INT_DIV  = 4'hC,
    INT_MOD  = 4'hD,
    INT_DIVU = 4'hE,
    INT_MODU = 4'hF
  } intfunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } intdiv_state_t;

  // True for the four operations handled by the divide unit.
  function automatic logic is_div_func(input intfunc_t f);
    return (f == INT_DIV) || (f == INT_MOD) || (f == INT_DIVU) || (f == INT_MODU);
  endfunction

endpackage

// File: rtl/intdiv_step.sv
// One radix-2 restoring division step (combinational).
//   r      : partial remainder in
//   q      : shifting dividend / quotient register in
//   d      : divisor
//   r_next : partial remainder out
//   q_next : dividend/quotient shifted left with the new quotient bit in bit 0
module intdiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] diff;

  // Keep the full WIDTH+1-bit shifted remainder so the compare is exact.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    diff    = r_shift - {1'b0, d};
    if (!diff[WIDTH]) begin
      r_next = diff[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = r_shift[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/intdiv.sv
// Multi-cycle integer divide unit: DIV/MOD/DIVU/MODU, one quotient bit per cycle.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : synchronous abort of any operation in flight
//   in_valid/in_ready : request handshake; func, a (dividend), b (divisor) sampled on accept
//   out_valid/out_ready : result handshake; result holds quotient or remainder
module intdiv
  import bexkat1Def::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  intfunc_t         func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  intdiv_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             is_mod_q, is_mod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] r_next, q_next;
  logic             req_signed, req_mod;
  logic [WIDTH-1:0] a_abs, b_abs;

  intdiv_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Operand decode; magnitudes only matter for the signed ops.
  always_comb begin
    req_signed = (func == INT_DIV) || (func == INT_MOD);
    req_mod    = (func == INT_MOD) || (func == INT_MODU);
    a_abs      = (req_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    b_abs      = (req_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    is_mod_d    = is_mod_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (flush_i) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_d = 1'b0;
            if (!is_div_func(func)) begin
              result_d    = '0;
              state_d     = DONE;
              out_valid_d = 1'b1;
            end else if (b == '0) begin
              result_d    = req_mod ? a : '1;
              state_d     = DONE;
              out_valid_d = 1'b1;
            end else if (req_signed && (a == MIN_VAL) && (b == '1)) begin
              result_d    = req_mod ? '0 : MIN_VAL;
              state_d     = DONE;
              out_valid_d = 1'b1;
            end else begin
              r_d      = '0;
              q_d      = a_abs;
              d_d      = b_abs;
              qneg_d   = req_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d   = req_signed & a[WIDTH-1];
              is_mod_d = req_mod;
              count_d  = CW'(WIDTH - 1);
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          r_d = r_next;
          q_d = q_next;
          if (count_q == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            if (is_mod_q) begin
              result_d = rneg_q ? (WIDTH'(0) - r_next) : r_next;
            end else begin
              result_d = qneg_q ? (WIDTH'(0) - q_next) : q_next;
            end
          end else begin
            count_d = count_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      is_mod_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      is_mod_q    <= is_mod_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_intdiv.sv
// Directed-vector bench for the integer divide unit.
module tb_intdiv;
  import bexkat1Def::*;

  localparam int unsigned W = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  intfunc_t      func = INT_ADD;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;

  int tests = 0;
  int fails = 0;

  intdiv #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string         name;
    intfunc_t      f;
    logic [W-1:0]  av;
    logic [W-1:0]  bv;
    logic [W-1:0]  exp;
    int            lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge. Issues a request and waits for out_valid.
  task automatic issue(input intfunc_t f, input logic [W-1:0] av, input logic [W-1:0] bv);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk_i); #1; w++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    func     = f;
    a        = av;
    b        = bv;
    @(posedge clk_i); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] res, output int lat);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!out_valid && lat < 100);
    res = result;
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    @(posedge clk_i); #1;
    out_ready = 1'b0;
  endtask

  logic [W-1:0] res;
  logic [W-1:0] held;
  int           lat;
  logic         ok;

  initial begin
    vecs.push_back('{"divu_100_7",     INT_DIVU, 32'd100,        32'd7,          32'd14,         32});
    vecs.push_back('{"modu_100_7",     INT_MODU, 32'd100,        32'd7,          32'd2,          32});
    vecs.push_back('{"div_m100_7",     INT_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32});
    vecs.push_back('{"mod_m100_7",     INT_MOD,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   32});
    vecs.push_back('{"mod_100_m7",     INT_MOD,  32'd100,        32'hFFFFFFF9,   32'd2,          32});
    vecs.push_back('{"div_7_m2",       INT_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32});
    vecs.push_back('{"div_m7_m2",      INT_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32});
    vecs.push_back('{"mod_m7_m2",      INT_MOD,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   32});
    vecs.push_back('{"divu_max_max",   INT_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32});
    vecs.push_back('{"modu_big",       INT_MODU, 32'hFFFFFFFE,   32'hFFFFFFFF,   32'hFFFFFFFE,   32});
    vecs.push_back('{"divu_max_3",     INT_DIVU, 32'hFFFFFFFF,   32'd3,          32'h55555555,   32});
    vecs.push_back('{"divu_by0",       INT_DIVU, 32'h1234,       32'd0,          32'hFFFFFFFF,   1});
    vecs.push_back('{"mod_by0",        INT_MOD,  32'h1234,       32'd0,          32'h1234,       1});
    vecs.push_back('{"div_by0",        INT_DIV,  32'h1234,       32'd0,          32'hFFFFFFFF,   1});
    vecs.push_back('{"div_ovf",        INT_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
    vecs.push_back('{"mod_ovf",        INT_MOD,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1});
    vecs.push_back('{"non_div_func",   INT_ADD,  32'd5,          32'd3,          32'd0,          1});

    // Reset values.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].av, vecs[i].bv);
      wait_result(res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      deliver();
      check({vecs[i].name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    end

    // Backpressure: result held, in_ready low while out_ready is low.
    issue(INT_DIVU, 32'd100, 32'd7);
    wait_result(res, lat);
    held = result;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      if (result !== held || !out_valid || in_ready) ok = 1'b0;
    end
    check("bp_result", result, 32'd14);
    check("bp_hold_stable", 32'(ok), 32'd1);
    out_ready = 1'b1;
    #2;
    check("bp_in_ready_before_hs", 32'(in_ready), 32'd0);
    @(posedge clk_i); #1;
    out_ready = 1'b0;
    check("bp_in_ready_after_hs", 32'(in_ready), 32'd1);
    check("bp_out_valid_after_hs", 32'(out_valid), 32'd0);

    // Flush in the middle of CALC.
    issue(INT_DIVU, 32'd1000, 32'd9);
    repeat (5) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i); #1;
      if (out_valid) ok = 1'b0;
    end
    check("flush_no_out_valid", 32'(ok), 32'd1);
    check("flush_result_kept", result, 32'd14);
    issue(INT_DIVU, 32'hFFFFFFFF, 32'd3);
    wait_result(res, lat);
    check("post_flush_result", res, 32'h55555555);
    check("post_flush_latency", 32'(lat), 32'd32);
    deliver();

    // Asynchronous reset in the middle of CALC.
    issue(INT_DIVU, 32'd1000, 32'd9);
    repeat (5) begin @(posedge clk_i); #1; end
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid_after", 32'(out_valid), 32'd0);
    issue(INT_DIVU, 32'hFFFFFFFF, 32'd3);
    wait_result(res, lat);
    check("post_rst_result", res, 32'h55555555);
    check("post_rst_latency", 32'(lat), 32'd32);
    deliver();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
